gray_counter_param: RTL and testbench

- Parametrised WIDTH-bit Gray-code counter. It replaces hand-chained single-bit Gray cells in the gray_tree counters.
- Adds the following over the fixed-chain counter:
  - up/down direction
  - count enable
  - synchronous clear and load
  - wrap or saturate mode
  - a registered terminal-count pulse
  - a registered binary mirror of the count
- Sits beside the clk_master domain logic. Its Gray output feeds sine lookup and cross-domain sampling, so only one bit of gray_q may change per edge.

---
 rtl/gray_pkg.sv | 19 +
 rtl/gray_step_cell.sv | 18 +
 rtl/gray_counter_param.sv | 94 +++++++++
 tb/tb_gray_counter_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: Gray/binary conversion and parity helpers shared by the Gray counters
package gray_pkg;
    localparam int GRAY_MAX_W = 16;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int k = GRAY_MAX_W - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    function automatic logic parity(input logic [GRAY_MAX_W-1:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/gray_step_cell.sv
// gray_step_cell: decides whether one Gray bit toggles on a counting step
module gray_step_cell #(
    parameter bit IS_LSB = 1'b0,
    parameter bit IS_MSB = 1'b0
) (
    input  logic en,
    input  logic up,
    input  logic par,
    input  logic no_ones_below,
    input  logic q_below,
    output logic toggle
);
    logic w_sel0;
    // bit 0 moves on even parity going up, odd parity going down
    assign w_sel0 = par ^ up;
    // the MSB also absorbs the "no lower bit set" case (1000 up, 0000 down)
    assign toggle = en & (IS_LSB ? w_sel0 : ~w_sel0 & no_ones_below & (IS_MSB | q_below));
endmodule

// File: rtl/gray_counter_param.sv
// gray_counter_param: WIDTH-bit up/down Gray counter with clear, load, wrap/saturate,
// terminal-count pulse and a registered binary mirror
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk_master,
    input  logic             rstb,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_q,
    output logic             tc
);
    localparam logic [WIDTH-1:0] BIN_RST  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] GRAY_RST = WIDTH'(bin2gray(GRAY_MAX_W'(BIN_RST)));

    logic [WIDTH-1:0] r_gray, r_bin, w_toggle, w_q_below, w_low_zero, w_gray_nxt, w_bin_nxt;
    logic r_tc, r_hit, w_par, w_at_end, w_step, w_tc_nxt, w_hit_nxt;

    assign w_par     = parity(GRAY_MAX_W'(r_gray));
    assign w_at_end  = up ? &r_bin : ~|r_bin;
    assign w_step    = en & ~(SATURATE & w_at_end);
    assign w_q_below = {r_gray[WIDTH-2:0], 1'b0};

    always_comb begin
        w_low_zero[0] = 1'b1;
        for (int k = 1; k < WIDTH; k++) w_low_zero[k] = w_low_zero[k-1] & ~w_q_below[k-1];
    end

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        gray_step_cell #(
            .IS_LSB(i == 0),
            .IS_MSB(i == WIDTH - 1)
        ) u_cell (
            .en           (w_step),
            .up           (up),
            .par          (w_par),
            .no_ones_below(w_low_zero[i]),
            .q_below      (w_q_below[i]),
            .toggle       (w_toggle[i])
        );
    end

    // r_hit remembers that the current saturation block already pulsed tc
    always_comb begin
        w_gray_nxt = r_gray;
        w_bin_nxt  = r_bin;
        w_tc_nxt   = 1'b0;
        w_hit_nxt  = r_hit;
        if (clr) begin
            w_gray_nxt = '0;
            w_bin_nxt  = '0;
            w_hit_nxt  = 1'b0;
        end else if (load) begin
            w_gray_nxt = WIDTH'(bin2gray(GRAY_MAX_W'(load_val)));
            w_bin_nxt  = load_val;
            w_hit_nxt  = 1'b0;
        end else if (w_step) begin
            w_gray_nxt = r_gray ^ w_toggle;
            w_bin_nxt  = up ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1);
            w_tc_nxt   = w_at_end;
            w_hit_nxt  = 1'b0;
        end else if (en) begin
            w_tc_nxt  = ~r_hit;
            w_hit_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            r_gray <= GRAY_RST;
            r_bin  <= BIN_RST;
            r_tc   <= 1'b0;
            r_hit  <= 1'b0;
        end else begin
            r_gray <= w_gray_nxt;
            r_bin  <= w_bin_nxt;
            r_tc   <= w_tc_nxt;
            r_hit  <= w_hit_nxt;
        end
    end

    assign gray_q = r_gray;
    assign bin_q  = r_bin;
    assign tc     = r_tc;
endmodule

// File: tb/tb_gray_counter_param.sv
// tb_gray_counter_param: three counter variants driven together, checked against an arithmetic model
module tb_gray_counter_param;
    localparam int W[3]   = '{4, 4, 7};
    localparam int SAT[3] = '{0, 1, 0};
    localparam int RV[3]  = '{3, 0, 0};
    localparam logic [3:0] GS[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                      4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    localparam int DN[6] = '{4, 3, 2, 1, 0, 15};

    logic clk = 1'b0, rstb = 1'b1, en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [6:0] lv = '0;
    logic [3:0] g0, b0, g1, b1;
    logic [6:0] g2, b2;
    logic t0, t1, t2;
    logic [15:0] d_gray[3], d_bin[3], prev[3];
    logic d_tc[3];
    logic [15:0] m_bin[3], n_bin[3];
    bit m_tc[3], n_tc[3], m_hit[3], n_hit[3], m_jmp[3], n_jmp[3];
    bit chk_on = 1'b0;
    int n_vec = 0, n_err = 0;
    int mx;
    bit at_end;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(3)) u_w4 (
        .clk_master(clk), .rstb(rstb), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[3:0]), .gray_q(g0), .bin_q(b0), .tc(t0));
    gray_counter_param #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(0)) u_sat (
        .clk_master(clk), .rstb(rstb), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[3:0]), .gray_q(g1), .bin_q(b1), .tc(t1));
    gray_counter_param #(.WIDTH(7), .SATURATE(1'b0), .RST_VAL(0)) u_w7 (
        .clk_master(clk), .rstb(rstb), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .gray_q(g2), .bin_q(b2), .tc(t2));

    assign d_gray[0] = 16'(g0);
    assign d_gray[1] = 16'(g1);
    assign d_gray[2] = 16'(g2);
    assign d_bin[0]  = 16'(b0);
    assign d_bin[1]  = 16'(b1);
    assign d_bin[2]  = 16'(b2);
    assign d_tc[0]   = t0;
    assign d_tc[1]   = t1;
    assign d_tc[2]   = t2;

    // model: the count is an integer modulo 2^W; Gray is derived from it only for comparison
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mx       = (1 << W[k]) - 1;
            at_end   = up ? (int'(m_bin[k]) == mx) : (m_bin[k] == 16'd0);
            n_bin[k] = m_bin[k];
            n_tc[k]  = 1'b0;
            n_hit[k] = m_hit[k];
            n_jmp[k] = 1'b0;
            if (clr) begin
                n_bin[k] = '0;
                n_hit[k] = 1'b0;
                n_jmp[k] = 1'b1;
            end else if (load) begin
                n_bin[k] = 16'(int'(lv) & mx);
                n_hit[k] = 1'b0;
                n_jmp[k] = 1'b1;
            end else if (en && SAT[k] == 1 && at_end) begin
                n_tc[k]  = !m_hit[k];
                n_hit[k] = 1'b1;
            end else if (en) begin
                n_bin[k] = 16'((int'(m_bin[k]) + (up ? 1 : mx)) & mx);
                n_tc[k]  = at_end;
                n_hit[k] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rstb) begin
        for (int k = 0; k < 3; k++) begin
            if (!rstb) begin
                m_bin[k] <= 16'(RV[k]);
                m_tc[k]  <= 1'b0;
                m_hit[k] <= 1'b0;
                m_jmp[k] <= 1'b1;
            end else begin
                m_bin[k] <= n_bin[k];
                m_tc[k]  <= n_tc[k];
                m_hit[k] <= n_hit[k];
                m_jmp[k] <= n_jmp[k];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_gray[%0d]", k), 32'(d_gray[k]), 32'(m_bin[k] ^ (m_bin[k] >> 1)));
                chk($sformatf("model_bin[%0d]", k), 32'(d_bin[k]), 32'(m_bin[k]));
                chk($sformatf("model_tc[%0d]", k), 32'(d_tc[k]), 32'(m_tc[k]));
                if (!m_jmp[k])
                    chk($sformatf("one_bit_step[%0d]", k), 32'($countones(prev[k] ^ d_gray[k]) <= 1), 32'd1);
                prev[k] <= d_gray[k];
            end
        end
    end

    task automatic cyc(input logic e, input logic u, input logic c, input logic l, input logic [6:0] v);
        en = e; up = u; clr = c; load = l; lv = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rstb = 1'b0;
        #1 chk_on = 1'b1;
        chk("rst_gray_w4", 32'(g0), 32'h2);
        chk("rst_bin_w4", 32'(b0), 32'd3);
        chk("rst_tc_w4", 32'(t0), 32'd0);
        chk("rst_bin_sat", 32'(b1), 32'd0);
        chk("rst_gray_w7", 32'(g2), 32'd0);
        #1 rstb = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        chk("clr_bin", 32'(b0), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 0, 7'd0);
            chk($sformatf("up_seq_gray[%0d]", i), 32'(g0), 32'(GS[i]));
            chk($sformatf("up_seq_tc[%0d]", i), 32'(t0), 32'(i == 15));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd5);
        chk("load5_gray", 32'(g0), 32'h7);
        chk("load5_bin", 32'(b0), 32'd5);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
            chk($sformatf("down_bin[%0d]", i), 32'(b0), 32'(DN[i]));
            chk($sformatf("down_tc[%0d]", i), 32'(t0), 32'(i == 5));
        end
        chk("down_end_gray", 32'(g0), 32'h8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd14);
        chk("sat_load14", 32'(b1), 32'd14);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
            chk($sformatf("sat_bin[%0d]", i), 32'(b1), 32'd15);
            chk($sformatf("sat_tc[%0d]", i), 32'(t1), 32'(i == 1));
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        chk("sat_reverse", 32'(b1), 32'd14);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd9);
        chk("prio_pre", 32'(b0), 32'd9);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 7'd12);
        chk("prio_clr_bin", 32'(b0), 32'd0);
        chk("prio_clr_tc", 32'(t0), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd12);
        chk("prio_load_gray", 32'(g0), 32'hA);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 7'd6);
        chk("arst_pre", 32'(b0), 32'd6);
        #1 rstb = 1'b0;
        #1;
        chk("arst_gray", 32'(g0), 32'h2);
        chk("arst_bin", 32'(b0), 32'd3);
        chk("arst_tc", 32'(t0), 32'd0);
        #1 rstb = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
        chk("arst_resume_bin", 32'(b0), 32'd4);
        chk("arst_resume_gray", 32'(g0), 32'h6);
        for (int i = 0; i < 10000; i++)
            cyc($urandom_range(3) != 0, 1'($urandom), $urandom_range(49) == 0,
                $urandom_range(29) == 0, 7'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
